// File: rtl/br_enc_pkg.sv
// Shared types for the onehot-to-binary encoder.
// Holds the multihot resolution policy enum.
package br_enc_pkg;

  typedef enum logic {
    BR_ENC_LOWEST_WINS  = 1'b0,
    BR_ENC_HIGHEST_WINS = 1'b1
  } br_enc_multihot_policy_e;

endpackage

// File: rtl/br_enc_onehot2bin_lane.sv
// One combinational onehot-to-binary lane.
// lane_i: onehot in; bin_o: index; multihot_o/zero_o: flags.
module br_enc_onehot2bin_lane
  import br_enc_pkg::*;
#(
  parameter int NumValues = 4,
  parameter int BinWidth  = $clog2(NumValues),
  parameter br_enc_multihot_policy_e MultihotPolicy =
    BR_ENC_LOWEST_WINS
) (
  input  logic [NumValues-1:0] lane_i,
  output logic [BinWidth-1:0]  bin_o,
  output logic                 multihot_o,
  output logic                 zero_o
);

  localparam int CntW = $clog2(NumValues + 1);

  logic [CntW-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < NumValues; i++) begin
      ones = ones + CntW'(lane_i[i]);
    end
  end

  // Last assignment wins, so the scan direction
  // picks the surviving index on multihot lanes.
  always_comb begin
    bin_o = '0;
    if (MultihotPolicy == BR_ENC_HIGHEST_WINS) begin
      for (int i = 0; i < NumValues; i++) begin
        if (lane_i[i]) bin_o = BinWidth'(i);
      end
    end else begin
      for (int i = NumValues - 1; i >= 0; i--) begin
        if (lane_i[i]) bin_o = BinWidth'(i);
      end
    end
  end

  assign multihot_o = ones > CntW'(1);
  assign zero_o     = lane_i == '0;

endmodule

// File: rtl/br_enc_onehot2bin_pipe.sv
// Multi-lane onehot-to-binary encoder, 2-entry skid buffer.
// in/in_valid/in_ready -> out/out_valid/out_ready, err_count.
module br_enc_onehot2bin_pipe
  import br_enc_pkg::*;
#(
  parameter int NumValues   = 4,
  parameter int NumChannels = 1,
  parameter int BinWidth    = $clog2(NumValues),
  parameter br_enc_multihot_policy_e MultihotPolicy =
    BR_ENC_LOWEST_WINS,
  parameter int ErrCountWidth = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [NumChannels*NumValues-1:0] in,
  output logic out_valid,
  input  logic out_ready,
  output logic [NumChannels*BinWidth-1:0] out,
  output logic [NumChannels-1:0] out_multihot,
  output logic [NumChannels-1:0] out_zero,
  input  logic err_clear,
  output logic [ErrCountWidth-1:0] err_count
);

  typedef struct packed {
    logic [BinWidth-1:0] bin;
    logic                multihot;
    logic                zero;
  } lane_res_t;

  lane_res_t [NumChannels-1:0] enc;
  lane_res_t [NumChannels-1:0] head_q, head_d;
  lane_res_t [NumChannels-1:0] skid_q, skid_d;
  logic [NumChannels-1:0]      mh_vec;
  logic [1:0]                  cnt_q, cnt_d;
  logic [ErrCountWidth-1:0]    err_q, err_d;
  logic                        push, pop, err_inc;

  for (genvar c = 0; c < NumChannels; c++) begin : g_lane
    br_enc_onehot2bin_lane #(
      .NumValues      (NumValues),
      .BinWidth       (BinWidth),
      .MultihotPolicy (MultihotPolicy)
    ) u_lane (
      .lane_i     (in[c*NumValues +: NumValues]),
      .bin_o      (enc[c].bin),
      .multihot_o (enc[c].multihot),
      .zero_o     (enc[c].zero)
    );
    assign mh_vec[c] = enc[c].multihot;
    assign out[c*BinWidth +: BinWidth] = head_q[c].bin;
    assign out_multihot[c] = head_q[c].multihot;
    assign out_zero[c]     = head_q[c].zero;
  end

  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign err_inc   = push && (|mh_vec);
  assign err_count = err_q;

  // Push+pop only happens at occupancy 1, so the
  // new beat goes straight into head.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = enc;
        else               skid_d = enc;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = skid_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: head_d = enc;
      default: ;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_clear) begin
      err_d = err_inc ? ErrCountWidth'(1) : '0;
    end else if (err_inc && (err_q != '1)) begin
      err_d = err_q + ErrCountWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  a_nv: assert property (@(posedge clk) NumValues >= 2);
  a_nc: assert property (@(posedge clk) NumChannels >= 1);

  a_in_stable: assert property (@(posedge clk)
    disable iff (!rst_n)
    in_valid && !in_ready |=> in_valid && $stable(in));

  a_no_x: assert property (@(posedge clk)
    disable iff (!rst_n)
    !$isunknown({in_valid, out_ready, err_clear}));

  a_out_stable: assert property (@(posedge clk)
    disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid
      && $stable(out) && $stable(out_multihot)
      && $stable(out_zero));

  a_no_wrap: assert property (@(posedge clk)
    disable iff (!rst_n)
    (err_q == '1) && !err_clear |=> err_q == '1);

  for (genvar c = 0; c < NumChannels; c++) begin : g_rng
    a_bin_rng: assert property (@(posedge clk)
      disable iff (!rst_n)
      32'(out[c*BinWidth +: BinWidth]) < NumValues);
  end

endmodule

// File: tb/tb_br_enc_onehot2bin_pipe.sv
// Randomised bench for br_enc_onehot2bin_pipe.
// Two instances (lowest/highest wins) share one stimulus.
module tb_br_enc_onehot2bin_pipe;
  import br_enc_pkg::*;

  localparam int NV = 5;
  localparam int NC = 2;
  localparam int BW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic err_clear = 1'b0;
  logic [NC*NV-1:0] din = '0;

  logic lo_in_ready, lo_out_valid;
  logic hi_in_ready, hi_out_valid;
  logic [NC*BW-1:0] lo_out, hi_out;
  logic [NC-1:0] lo_mh, lo_zero, hi_mh, hi_zero;
  logic [7:0] lo_err;
  logic [1:0] hi_err;

  int n_checks = 0;
  int n_fail = 0;
  logic [NC*NV-1:0] q[$];
  int elo = 0;
  int ehi = 0;
  bit acc;

  always #5 clk = ~clk;

  br_enc_onehot2bin_pipe #(
    .NumValues(NV), .NumChannels(NC),
    .MultihotPolicy(BR_ENC_LOWEST_WINS),
    .ErrCountWidth(8)
  ) u_lo (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(lo_in_ready),
    .in(din),
    .out_valid(lo_out_valid), .out_ready(out_ready),
    .out(lo_out), .out_multihot(lo_mh),
    .out_zero(lo_zero),
    .err_clear(err_clear), .err_count(lo_err)
  );

  br_enc_onehot2bin_pipe #(
    .NumValues(NV), .NumChannels(NC),
    .MultihotPolicy(BR_ENC_HIGHEST_WINS),
    .ErrCountWidth(2)
  ) u_hi (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(hi_in_ready),
    .in(din),
    .out_valid(hi_out_valid), .out_ready(out_ready),
    .out(hi_out), .out_multihot(hi_mh),
    .out_zero(hi_zero),
    .err_clear(err_clear), .err_count(hi_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int ref_bin(logic [NV-1:0] v, bit hi);
    if (v == '0) return 0;
    if (hi) begin
      for (int i = NV - 1; i >= 0; i--)
        if (v[i]) return i;
    end else begin
      for (int i = 0; i < NV; i++)
        if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic bit ref_mh(logic [NV-1:0] v);
    return $countones(v) > 1;
  endfunction

  function automatic logic [NV-1:0] gen_lane();
    case ($urandom_range(0, 3))
      0: return '0;
      1, 2: return NV'(1 << $urandom_range(0, NV - 1));
      default: return NV'($urandom);
    endcase
  endfunction

  task automatic check_outputs();
    logic [NV-1:0] v;
    chk("lo_in_ready", 32'(lo_in_ready), 32'(q.size() < 2));
    chk("hi_in_ready", 32'(hi_in_ready), 32'(q.size() < 2));
    chk("lo_out_valid", 32'(lo_out_valid), 32'(q.size() > 0));
    chk("hi_out_valid", 32'(hi_out_valid), 32'(q.size() > 0));
    chk("lo_err", 32'(lo_err), elo);
    chk("hi_err", 32'(hi_err), ehi);
    if (q.size() > 0) begin
      for (int c = 0; c < NC; c++) begin
        v = q[0][c*NV +: NV];
        chk("lo_bin", 32'(lo_out[c*BW +: BW]), ref_bin(v, 0));
        chk("hi_bin", 32'(hi_out[c*BW +: BW]), ref_bin(v, 1));
        chk("lo_mh", 32'(lo_mh[c]), 32'(ref_mh(v)));
        chk("hi_mh", 32'(hi_mh[c]), 32'(ref_mh(v)));
        chk("lo_zero", 32'(lo_zero[c]), 32'(v == '0));
        chk("hi_zero", 32'(hi_zero[c]), 32'(v == '0));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'({lo_out_valid, hi_out_valid}), 0);
    chk({tag, "_ready"}, 32'({lo_in_ready, hi_in_ready}), 3);
    chk({tag, "_out"}, 32'({lo_out, hi_out}), 0);
    chk({tag, "_flags"},
        32'({lo_mh, lo_zero, hi_mh, hi_zero}), 0);
    chk({tag, "_err"}, 32'({lo_err, hi_err}), 0);
  endtask

  // One clock: drive, check registered outputs, then
  // advance the model as the coming edge will.
  task automatic step(input logic iv,
                      input logic [NC*NV-1:0] d,
                      input logic ordy,
                      input logic clr);
    bit push, pop, mh;
    @(negedge clk);
    in_valid = iv;
    din = d;
    out_ready = ordy;
    err_clear = clr;
    #1;
    check_outputs();
    push = iv && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    mh = 0;
    for (int c = 0; c < NC; c++)
      if (ref_mh(d[c*NV +: NV])) mh = 1;
    mh = mh && push;
    if (clr) begin
      elo = mh ? 1 : 0;
      ehi = mh ? 1 : 0;
    end else if (mh) begin
      if (elo < 255) elo++;
      if (ehi < 3) ehi++;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    acc = push;
  endtask

  initial begin
    logic [NC*NV-1:0] a, b, cc, rd;
    bit iv, pend;

    repeat (2) @(negedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;

    step(1'b1, {5'b00001, 5'b01000}, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("clean_out", 32'(lo_out), 32'({3'd0, 3'd3}));
    chk("clean_flags", 32'({lo_mh, lo_zero}), 0);
    chk("clean_err", 32'(lo_err), 0);
    step(1'b0, '0, 1'b1, 1'b0);

    step(1'b1, {5'b00010, 5'b10100}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("mh_lowest", 32'(lo_out[2:0]), 2);
    chk("mh_highest", 32'(hi_out[2:0]), 4);
    chk("mh_flag", 32'(lo_mh), 32'(2'b01));
    chk("mh_err", 32'(lo_err), 1);
    step(1'b0, '0, 1'b1, 1'b0);

    a  = {5'b00100, 5'b00010};
    b  = {5'b10000, 5'b00000};
    cc = {5'b01000, 5'b11000};
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, cc, 1'b0, 1'b0);
    step(1'b1, cc, 1'b0, 1'b0);
    chk("bp_full", 32'(lo_in_ready), 0);
    chk("bp_hold_a", 32'(lo_out), 32'({3'd2, 3'd1}));
    step(1'b1, cc, 1'b1, 1'b0);
    step(1'b1, cc, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++)
      step(1'b1, {5'b00000, 5'b00011}, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("sat_hi", 32'(hi_err), 3);
    step(1'b1, {5'b00110, 5'b00000}, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("clr_hi", 32'(hi_err), 1);
    chk("clr_lo", 32'(lo_err), 1);

    step(1'b1, {5'b00001, 5'b00000}, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("zero_lane", 32'({lo_zero, lo_out[2:0]}), 32'({2'b01, 3'd0}));
    step(1'b1, {5'b00000, 5'b00001}, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bit0_lane", 32'({lo_zero, lo_mh, lo_out[2:0]}),
        32'({2'b10, 2'b00, 3'd0}));
    step(1'b0, '0, 1'b1, 1'b0);

    pend = 0;
    rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        iv = $urandom_range(0, 3) != 0;
        for (int c = 0; c < NC; c++) rd[c*NV +: NV] = gen_lane();
      end else begin
        iv = 1;
      end
      step(iv, rd, $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0);
      pend = iv && !acc;
    end

    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, cc, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    #1;
    q.delete();
    elo = 0;
    ehi = 0;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, b, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
